// File: rtl/signed_divider_4.sv
// rtl/signed_divider_4.sv - sequential signed restoring divider with valid/ready handshakes
// Optional macro SIGNED_DIV_FAST_TRIVIAL_EN: a==0 or b==0 bypasses CALC and goes straight to FIX.
module signed_divider_4 #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] q,
    output logic [N-1:0] r,
    output logic         div_by_zero,
    output logic         overflow
);

    localparam int CW = (N > 2) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t         state;
    state_t         state_next;
    logic           sign_a;
    logic           sign_b;
    logic [N-1:0]   a_raw;
    logic [N-1:0]   b_raw;
    logic [N-1:0]   dmag;
    logic [N-1:0]   bmag;
    logic [N:0]     rem;
    logic [CW-1:0]  cnt;

    logic [N-1:0]   a_abs;
    logic [N-1:0]   b_abs;
    logic [2*N:0]   pair;
    logic [N:0]     rem_sh;
    logic [N:0]     diff;
    logic           qbit;
    logic [N-1:0]   q_fix;
    logic [N-1:0]   r_fix;
    logic           dz_fix;
    logic           ov_fix;

    // |most-negative| = 2^(N-1) still fits as an N-bit unsigned magnitude
    assign a_abs = a[N-1] ? -a : a;
    assign b_abs = b[N-1] ? -b : b;

    // dmag shifts out dividend bits from the top and collects quotient bits at the bottom
    assign pair   = {rem, dmag} << 1;
    assign rem_sh = pair[2*N:N];
    assign diff   = rem_sh - {1'b0, bmag};
    assign qbit   = (rem_sh >= {1'b0, bmag});

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_comb begin
        q_fix  = (sign_a ^ sign_b) ? -dmag : dmag;
        r_fix  = sign_a ? -rem[N-1:0] : rem[N-1:0];
        dz_fix = (b_raw == '0);
        ov_fix = (a_raw == {1'b1, {(N-1){1'b0}}}) && (b_raw == '1);
        if (dz_fix) begin
            q_fix = '1;
            r_fix = a_raw;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (in_valid) begin
`ifdef SIGNED_DIV_FAST_TRIVIAL_EN
                    state_next = ((a == '0) || (b == '0)) ? FIX : CALC;
`else
                    state_next = CALC;
`endif
                end
            end
            CALC:    if (cnt == '0) state_next = FIX;
            FIX:     state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sign_a      <= 1'b0;
            sign_b      <= 1'b0;
            a_raw       <= '0;
            b_raw       <= '0;
            dmag        <= '0;
            bmag        <= '0;
            rem         <= '0;
            cnt         <= '0;
            q           <= '0;
            r           <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sign_a      <= a[N-1];
                        sign_b      <= b[N-1];
                        a_raw       <= a;
                        b_raw       <= b;
                        dmag        <= a_abs;
                        bmag        <= b_abs;
                        rem         <= '0;
                        cnt         <= CW'(N - 1);
                        div_by_zero <= 1'b0;
                        overflow    <= 1'b0;
                    end
                end
                CALC: begin
                    rem  <= qbit ? diff : rem_sh;
                    dmag <= pair[N-1:0] | {{(N-1){1'b0}}, qbit};
                    cnt  <= cnt - CW'(1);
                end
                FIX: begin
                    q           <= q_fix;
                    r           <= r_fix;
                    div_by_zero <= dz_fix;
                    overflow    <= ov_fix;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_signed_divider_4.sv
// tb/tb_signed_divider_4.sv - scoreboard bench for signed_divider_4
module tb_signed_divider_4;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b1;
    logic [N-1:0] a = '0;
    logic [N-1:0] b = '0;
    logic         in_ready;
    logic         out_valid;
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         div_by_zero;
    logic         overflow;

    int checks = 0;
    int errors = 0;
    logic [9:0] sb[$];

    signed_divider_4 #(.N(N)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready),
        .q(q), .r(r), .div_by_zero(div_by_zero), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // result packed as {q, r, div_by_zero, overflow}
    function automatic logic [9:0] model(input logic [3:0] av, input logic [3:0] bv);
        int ai, bi, qi, ri;
        logic [3:0] qq, rr;
        logic dz, ov;
        ai = int'($signed(av));
        bi = int'($signed(bv));
        qi = 0; ri = 0; dz = 1'b0; ov = 1'b0;
        if (bi == 0) begin
            qq = 4'hF; rr = av; dz = 1'b1;
        end else if (ai == -8 && bi == -1) begin
            qq = 4'h8; rr = 4'h0; ov = 1'b1;
        end else begin
            qi = ai / bi;
            ri = ai % bi;
            qq = qi[3:0];
            rr = ri[3:0];
        end
        return {qq, rr, dz, ov};
    endfunction

    function automatic int exp_lat(input logic [3:0] av, input logic [3:0] bv);
`ifdef SIGNED_DIV_FAST_TRIVIAL_EN
        if (av == 4'h0 || bv == 4'h0) return 2;
`endif
        if (av == bv) return 6;
        return 6;
    endfunction

    // drives one operation with out_ready high; lat counts edges from accept to out_valid (-1 on timeout)
    task automatic run_op(input logic [3:0] av, input logic [3:0] bv, output int lat, output logic [9:0] got);
        int n;
        out_ready = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        a = av; b = bv; in_valid = 1'b1;
        sb.push_back(model(av, bv));
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 1;
        n = 0;
        while (n < 50) begin
            @(negedge clk);
            if (out_valid) break;
            @(posedge clk);
            lat++;
            n++;
        end
        if (!out_valid) lat = -1;
        got = {q, r, div_by_zero, overflow};
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++;
        if ({in_ready, out_valid, q, r, div_by_zero, overflow} !== 12'b10_0000_0000_00) begin
            errors++;
            $display("FAIL reset_state got %b exp %b", {in_ready, out_valid, q, r, div_by_zero, overflow}, 12'b10_0000_0000_00);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        logic [3:0] ta[3] = '{4'h7, 4'h9, 4'h7};
        logic [3:0] tb[3] = '{4'h2, 4'h2, 4'hE};
        logic [9:0] te[3] = '{{4'h3, 4'h1, 2'b00}, {4'hD, 4'hF, 2'b00}, {4'hD, 4'h1, 2'b00}};
        logic [9:0] got, exp;
        int lat;
        for (int i = 0; i < 3; i++) begin
            run_op(ta[i], tb[i], lat, got);
            exp = sb.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL basic_sb[%0d] got %h exp %h", i, got, exp);
            end
            checks++;
            if (got !== te[i]) begin
                errors++;
                $display("FAIL basic_const[%0d] got %h exp %h", i, got, te[i]);
            end
            checks++;
            if (lat != 6) begin
                errors++;
                $display("FAIL basic_latency[%0d] got %0d exp 6", i, lat);
            end
        end
    endtask

    task automatic test_special();
        logic [9:0] got, exp;
        int lat, n;
        run_op(4'h8, 4'hF, lat, got);
        exp = sb.pop_front();
        checks++;
        if (got !== exp || got !== {4'h8, 4'h0, 2'b01}) begin
            errors++;
            $display("FAIL overflow got %h exp %h", got, exp);
        end
        checks++;
        if (lat != 6) begin
            errors++;
            $display("FAIL overflow_latency got %0d exp 6", lat);
        end
        run_op(4'h5, 4'h0, lat, got);
        exp = sb.pop_front();
        checks++;
        if (got !== exp || got !== {4'hF, 4'h5, 2'b10}) begin
            errors++;
            $display("FAIL div_zero got %h exp %h", got, exp);
        end
        checks++;
        if (lat != exp_lat(4'h5, 4'h0)) begin
            errors++;
            $display("FAIL div_zero_latency got %0d exp %0d", lat, exp_lat(4'h5, 4'h0));
        end
        checks++;
        if ({out_valid, div_by_zero} !== 2'b01) begin
            errors++;
            $display("FAIL flag_persist got ov/dz %b exp 01", {out_valid, div_by_zero});
        end
        a = 4'h7; b = 4'h2; in_valid = 1'b1;
        sb.push_back(model(4'h7, 4'h2));
        @(posedge clk);
        #1 in_valid = 1'b0;
        checks++;
        if ({div_by_zero, overflow, in_ready} !== 3'b000) begin
            errors++;
            $display("FAIL flag_clear_on_accept got %b exp 000", {div_by_zero, overflow, in_ready});
        end
        n = 0;
        while (!out_valid && n < 50) begin
            @(posedge clk);
            #1 n++;
        end
        exp = sb.pop_front();
        checks++;
        if ({q, r, div_by_zero, overflow} !== exp) begin
            errors++;
            $display("FAIL after_clear got %h exp %h", {q, r, div_by_zero, overflow}, exp);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_backpressure();
        logic [9:0] exp;
        int n;
        out_ready = 1'b0;
        a = 4'h6; b = 4'h3; in_valid = 1'b1;
        sb.push_back(model(4'h6, 4'h3));
        @(posedge clk);
        #1 in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 50) begin
            @(posedge clk);
            #1 n++;
        end
        exp = sb.pop_front();
        checks++;
        if ({q, r, div_by_zero, overflow} !== exp || exp !== {4'h2, 4'h0, 2'b00}) begin
            errors++;
            $display("FAIL bp_result got %h exp %h", {q, r, div_by_zero, overflow}, exp);
        end
        for (int i = 0; i < 4; i++) begin
            a = 4'h1; b = 4'h1; in_valid = 1'b1;
            @(posedge clk);
            #1;
            checks++;
            if ({out_valid, in_ready, q, r, div_by_zero, overflow} !== {2'b10, exp}) begin
                errors++;
                $display("FAIL bp_hold[%0d] got %h exp %h", i, {out_valid, in_ready, q, r, div_by_zero, overflow}, {2'b10, exp});
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            errors++;
            $display("FAIL bp_release got %b exp 01", {out_valid, in_ready});
        end
        @(posedge clk);
        #1;
        checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            errors++;
            $display("FAIL bp_no_stray_op got %b exp 01", {out_valid, in_ready});
        end
    endtask

    task automatic test_reset_midcalc();
        logic [9:0] got, exp;
        int lat;
        logic bad;
        a = 4'h7; b = 4'h2; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({in_ready, out_valid, q, r, div_by_zero, overflow} !== 12'b10_0000_0000_00) begin
            errors++;
            $display("FAIL midcalc_reset got %b exp %b", {in_ready, out_valid, q, r, div_by_zero, overflow}, 12'b10_0000_0000_00);
        end
        @(negedge clk);
        rst_n = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL midcalc_spurious_valid got 1 exp 0");
        end
        run_op(4'h7, 4'h2, lat, got);
        exp = sb.pop_front();
        checks++;
        if (got !== exp || lat != 6) begin
            errors++;
            $display("FAIL midcalc_recover got %h lat %0d exp %h lat 6", got, lat, exp);
        end
    endtask

    task automatic test_sweep();
        logic [9:0] got, exp;
        int lat;
        logic [3:0] av, bv;
        for (int i = 0; i < 256; i++) begin
            av = i[7:4];
            bv = i[3:0];
            run_op(av, bv, lat, got);
            exp = sb.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL sweep a=%h b=%h got %h exp %h", av, bv, got, exp);
            end
            checks++;
            if (lat != exp_lat(av, bv)) begin
                errors++;
                $display("FAIL sweep_latency a=%h b=%h got %0d exp %0d", av, bv, lat, exp_lat(av, bv));
            end
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d exp 0", sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_special();
        test_backpressure();
        test_reset_midcalc();
        test_sweep();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/signed_divider_4.md
Name: signed_divider_4

Overview:
- Sequential signed two's-complement divider for the computational core. It is the inverse-direction companion to the combinational signed add/sub datapath.
- Takes N-bit dividend and divisor, produces N-bit quotient and remainder over multiple cycles using restoring shift-subtract on magnitudes.
- Valid/ready handshake on input and output, so it can sit between operand registers and the result bus.

Parameters:
N, 4, operand/result width in bits (N >= 2)

Ports:
clk  input  1  system clock, rising-edge
rst_n  input  1  reset, asynchronous assert, active-low
in_valid  input  1  operands a/b present
in_ready  output  1  divider can accept operands
a  input  N  dividend, signed two's complement
b  input  N  divisor, signed two's complement
out_valid  output  1  q/r/flags valid
out_ready  input  1  consumer accepts result
q  output  N  quotient, signed, truncated toward zero
r  output  N  remainder, signed, same sign as dividend (or zero)
div_by_zero  output  1  b was zero for this result
overflow  output  1  quotient not representable (most-negative / -1)

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; in_ready=1; out_valid=0; q=0; r=0; div_by_zero=0; overflow=0; all internal registers cleared.
- States: IDLE, CALC, FIX, DONE.
- IDLE: in_ready=1. On in_valid&in_ready:
  - latch sign_a=a[N-1], sign_b=b[N-1].
  - latch |a| and |b| as N-bit unsigned. |most-negative| = 2^(N-1) fits unsigned.
  - clear N+1-bit partial remainder; set step counter=N-1; go to CALC.
- CALC: one quotient bit per cycle, MSB first.
  - shift {rem, dividend_mag} left by 1.
  - if rem >= |b|: rem -= |b| and the quotient bit = 1; otherwise the quotient bit = 0.
  - counter decrements; after the cycle with counter==0, go to FIX. CALC lasts exactly N cycles.
- FIX: one cycle.
  - q = (sign_a^sign_b) ? -qmag : qmag.
  - r = sign_a ? -rem : rem (N bits).
  - set flags; go to DONE.
- DONE: out_valid=1, outputs held stable. On out_valid&out_ready: out_valid=0, go to IDLE. in_ready=0 in CALC/FIX/DONE.
- Latency: accept edge to out_valid = N+2 cycles (6 for N=4). in_ready returns the cycle after the output handshake. There is no overlap of operations.
- Divide by zero (b==0):
  - data path still runs.
  - result forced in FIX: q = all ones, r = a, div_by_zero=1, overflow=0.
- Overflow (a = 1000..0, b = all ones):
  - q = 1000..0 (wrapped), r = 0, overflow=1.
- Zero remainder never gets a sign: r=0 when rem=0, regardless of sign_a.
- Flags are cleared on the next accept, not on the output handshake. They remain readable with out_valid low.
- in_valid asserted while busy is ignored; a and b are sampled only on accept.
- out_ready held high in IDLE has no effect.
- Reset mid-CALC/FIX/DONE aborts immediately to reset values. There is no partial result and no spurious out_valid after release.

Optional Feature:
- Macro: SIGNED_DIV_FAST_TRIVIAL_EN.
- Defined: when b==0 or a==0 at accept, skip CALC and go directly to FIX, giving latency 2 cycles. Results are identical to the full path: a==0 gives q=0, r=0; b==0 gives the div_by_zero rules above.
- Undefined: every operation takes the full N+2 cycles and no bypass logic is present.

Test Plan:
- a=0111 (7), b=0010 (2), out_ready=1 -> after 6 cycles out_valid=1, q=0011, r=0001, flags 0.
- a=1001 (-7), b=0010 -> q=1101 (-3), r=1111 (-1). Then a=0111, b=1110 (-2) -> q=1101, r=0001.
- a=1000 (-8), b=1111 (-1) -> q=1000, r=0000, overflow=1. Then a=0101, b=0000 -> q=1111, r=0101, div_by_zero=1. The latency is 6 without the macro and 2 with it.
- Backpressure: a=0110, b=0011 with out_ready=0 for 4 cycles after out_valid -> q=0010, r=0000 stable, in_ready=0, in_valid pulses ignored. out_ready=1 -> handshake, in_ready=1 the next cycle.
- Reset: drop rst_n in the 2nd CALC cycle -> outputs immediately at reset values. After release, out_valid stays 0. A new 7/2 operation completes correctly.
- Sweep all 256 (a,b) pairs for N=4 against a truncating-division model, including the b==0 and overflow rules.
